// File: rtl/monitor_sensores.sv
// monitor_sensores: sensor synchronizer, debouncer and fault-latching encoder for the error display.
//
// Ports:
//   clk                       system clock
//   reset                     asynchronous, active-high reset
//   s_temp, s_agua, s_cafe,
//   s_acucar, s_copo          raw fault sensors, 1 = fault
//   ack                       raw operator acknowledge button
//   A, B, C                   latched error code {A,B,C} for the digit-4 decoder
//   inibe                     brew inhibit, 1 whenever a fault is active or unacknowledged
//   pisca                     display blink enable
//
// Optional feature: define SENSOR_PISCA_EN to generate the blink output;
// otherwise pisca is tied to 0 and no blink counter exists.
module monitor_sensores #(
    parameter int DEB_CYCLES = 4,
    parameter int BLINK_DIV  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic s_temp,
    input  logic s_agua,
    input  logic s_cafe,
    input  logic s_acucar,
    input  logic s_copo,
    input  logic ack,
    output logic A,
    output logic B,
    output logic C,
    output logic inibe,
    output logic pisca
);
    typedef enum logic [1:0] {OK, ATIVO, ESPERA_ACK} state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CYCLES - 1);

    state_t     state, state_n;
    logic [2:0] code, code_n, pri;
    logic       inibe_r;
    logic [4:0] raw, sync1, sync2, deb;
    logic [7:0] cnt [5];
    logic       ack1, ack2, ack3, ack_p;

    // Bit order follows priority: temp, agua, cafe, acucar, copo.
    assign raw = {s_temp, s_agua, s_cafe, s_acucar, s_copo};

    // Codes are not ordered numerically, so comparisons go through a rank.
    function automatic logic [2:0] rank(input logic [2:0] c);
        return c == 3'b101 ? 3'd5 :
               c == 3'b001 ? 3'd4 :
               c == 3'b010 ? 3'd3 :
               c == 3'b011 ? 3'd2 :
               c == 3'b100 ? 3'd1 : 3'd0;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            ack1  <= 1'b0;
            ack2  <= 1'b0;
            ack3  <= 1'b0;
            ack_p <= 1'b0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            ack1  <= ack;
            ack2  <= ack1;
            ack3  <= ack2;
            ack_p <= ack2 & ~ack3;
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    // This is the DEB_CYCLES-th consecutive differing cycle.
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        pri = deb[4] ? 3'b101 :
              deb[3] ? 3'b001 :
              deb[2] ? 3'b010 :
              deb[1] ? 3'b011 :
              deb[0] ? 3'b100 : 3'b000;
    end

    always_comb begin
        state_n = state;
        code_n  = code;
        case (state)
            OK: begin
                if (|deb) begin
                    state_n = ATIVO;
                    code_n  = pri;
                end
            end
            ATIVO: begin
                if (!(|deb))
                    state_n = ESPERA_ACK;
                else if (rank(pri) > rank(code))
                    code_n = pri;
            end
            ESPERA_ACK: begin
                // A returning fault takes precedence over a simultaneous ack.
                if (|deb) begin
                    state_n = ATIVO;
                    code_n  = pri;
                end else if (ack_p) begin
                    state_n = OK;
                    code_n  = 3'b000;
                end
            end
            default: begin
                state_n = OK;
                code_n  = 3'b000;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= OK;
            code    <= 3'b000;
            inibe_r <= 1'b0;
        end else begin
            state   <= state_n;
            code    <= code_n;
            inibe_r <= state_n != OK;
        end
    end

    assign {A, B, C} = code;
    assign inibe     = inibe_r;

`ifdef SENSOR_PISCA_EN
    localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [BW-1:0] blink_cnt;
    logic          pisca_r;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt <= '0;
            pisca_r   <= 1'b0;
        end else if (state_n == ATIVO && state != ATIVO) begin
            // Every entry to ATIVO restarts the blink phase.
            blink_cnt <= '0;
            pisca_r   <= 1'b0;
        end else if (state_n == ATIVO) begin
            blink_cnt <= blink_cnt == BLINK_LAST ? '0 : blink_cnt + 1'b1;
            pisca_r   <= blink_cnt == BLINK_LAST ? ~pisca_r : pisca_r;
        end else begin
            blink_cnt <= '0;
            pisca_r   <= state_n == ESPERA_ACK;
        end
    end

    assign pisca = pisca_r;
`else
    // Always 0; BLINK_DIV is referenced so both builds share one parameter list.
    assign pisca = (BLINK_DIV < 1) & 1'b0;
`endif

endmodule

// File: tb/tb_monitor_sensores.sv
// tb_monitor_sensores: randomized and directed checks of monitor_sensores against a window-based reference model.
module tb_monitor_sensores;
    localparam int DEB   = 4;
    localparam int BLINK = 8;

    localparam logic [5:0] ACK  = 6'b100000;
    localparam logic [5:0] TEMP = 6'b010000;
    localparam logic [5:0] AGUA = 6'b001000;
    localparam logic [5:0] CAFE = 6'b000100;
    localparam logic [5:0] ACU  = 6'b000010;
    localparam logic [5:0] COPO = 6'b000001;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic s_temp = 1'b0, s_agua = 1'b0, s_cafe = 1'b0, s_acucar = 1'b0, s_copo = 1'b0, ack = 1'b0;
    logic A, B, C, inibe, pisca;

    int total = 0;
    int bad = 0;

    monitor_sensores #(.DEB_CYCLES(DEB), .BLINK_DIV(BLINK)) dut (
        .clk(clk), .reset(reset),
        .s_temp(s_temp), .s_agua(s_agua), .s_cafe(s_cafe), .s_acucar(s_acucar), .s_copo(s_copo),
        .ack(ack),
        .A(A), .B(B), .C(C), .inibe(inibe), .pisca(pisca)
    );

    always #5 clk = ~clk;

    // Reference model: raw input history per edge, debounce as a sliding window.
    logic [5:0] hist [0:8191];
    int         k;
    int         mstate;   // 0 = OK, 1 = ATIVO, 2 = ESPERA_ACK
    int         mrank;    // index of latched fault (4 = temp ... 0 = copo), -1 = none
    int         entry;
    logic [4:0] mdeb;
    logic [2:0] code_of [5];

    initial begin
        code_of[0] = 3'b100;
        code_of[1] = 3'b011;
        code_of[2] = 3'b010;
        code_of[3] = 3'b001;
        code_of[4] = 3'b101;
    end

    function automatic logic [5:0] h(input int j);
        return j < 1 ? 6'd0 : hist[j];
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at t=%0t: got=%0h expected=%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        k = 0;
        mstate = 0;
        mrank = -1;
        entry = 0;
        mdeb = '0;
    endtask

    task automatic model_edge(input logic [5:0] v);
        logic [5:0] a, b, w;
        logic       ackp, flip;
        int         top;
        k++;
        hist[k] = v;
        a = h(k - 3);
        b = h(k - 4);
        ackp = a[5] & ~b[5];
        top = -1;
        for (int i = 0; i < 5; i++) if (mdeb[i]) top = i;
        if (mstate == 0) begin
            if (top >= 0) begin mstate = 1; mrank = top; entry = k; end
        end else if (mstate == 1) begin
            if (top < 0) mstate = 2;
            else if (top > mrank) mrank = top;
        end else begin
            if (top >= 0) begin mstate = 1; mrank = top; entry = k; end
            else if (ackp) begin mstate = 0; mrank = -1; end
        end
        for (int i = 0; i < 5; i++) begin
            flip = 1'b1;
            for (int j = 0; j < DEB; j++) begin
                w = h(k - 2 - j);
                if (w[i] == mdeb[i]) flip = 1'b0;
            end
            if (flip) mdeb[i] = ~mdeb[i];
        end
    endtask

    task automatic step(input logic [5:0] v);
        logic [2:0] ecode;
        logic       episca;
        {ack, s_temp, s_agua, s_cafe, s_acucar, s_copo} = v;
        @(posedge clk);
        #1;
        model_edge(v);
        ecode = mrank < 0 ? 3'b000 : code_of[mrank];
`ifdef SENSOR_PISCA_EN
        episca = mstate == 2 ? 1'b1 : mstate == 1 ? 1'(((k - entry) / BLINK) % 2) : 1'b0;
`else
        episca = 1'b0;
`endif
        check("code", 8'({A, B, C}), 8'(ecode));
        check("inibe", 8'(inibe), 8'(mstate != 0));
        check("pisca", 8'(pisca), 8'(episca));
    endtask

    task automatic run(input logic [5:0] v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        check("rst_code", 8'({A, B, C}), 8'd0);
        check("rst_inibe", 8'(inibe), 8'd0);
        check("rst_pisca", 8'(pisca), 8'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    initial begin
        logic [5:0] cur;
        model_reset();
        @(posedge clk);
        #1;
        do_reset();

        // Held water-low fault latches exactly at edge 3+DEB.
        run(AGUA, 6);
        check("agua_e6_code", 8'({A, B, C}), 8'd0);
        check("agua_e6_inibe", 8'(inibe), 8'd0);
        step(AGUA);
        check("agua_e7_code", 8'({A, B, C}), 8'b001);
        check("agua_e7_inibe", 8'(inibe), 8'd1);
        run(6'd0, 10);
        run(ACK, 4);
        run(6'd0, 3);
        check("agua_acked", 8'({A, B, C}), 8'd0);

        // Glitch shorter than the debounce window is ignored.
        do_reset();
        run(CAFE, 3);
        run(6'd0, 12);
        check("glitch_code", 8'({A, B, C}), 8'd0);
        check("glitch_inibe", 8'(inibe), 8'd0);

        // Upgrade from copo to temp, no downgrade when temp clears.
        do_reset();
        run(COPO, 8);
        check("copo_code", 8'({A, B, C}), 8'b100);
        run(COPO | TEMP, 8);
        check("upgrade_code", 8'({A, B, C}), 8'b101);
        run(COPO, 10);
        check("keep_code", 8'({A, B, C}), 8'b101);
        check("keep_inibe", 8'(inibe), 8'd1);

        // Ack ignored while the fault is present; honoured once it clears.
        do_reset();
        run(CAFE, 8);
        run(CAFE | ACK, 10);
        check("ack_ativo_code", 8'({A, B, C}), 8'b010);
        run(CAFE, 2);
        run(6'd0, 8);
        check("espera_code", 8'({A, B, C}), 8'b010);
        run(ACK, 3);
        check("pre_ack_code", 8'({A, B, C}), 8'b010);
        check("pre_ack_inibe", 8'(inibe), 8'd1);
        step(ACK);
        check("ack_code", 8'({A, B, C}), 8'd0);
        check("ack_inibe", 8'(inibe), 8'd0);
        run(ACK, 20);
        check("ack_hold_inibe", 8'(inibe), 8'd0);

        // Fault returning in the same cycle as ack_p wins.
        do_reset();
        run(ACU, 8);
        run(6'd0, 8);
        check("acu_espera", 8'({A, B, C}), 8'b011);
        run(ACU, 3);
        run(ACU | ACK, 5);
        check("race_code", 8'({A, B, C}), 8'b011);
        check("race_inibe", 8'(inibe), 8'd1);

        // Asynchronous reset mid-fault, then re-latch of the held fault.
        do_reset();
        run(TEMP, 8);
        check("pre_rst_inibe", 8'(inibe), 8'd1);
        do_reset();
        run(TEMP, 3 + DEB - 1);
        check("relatch_early", 8'({A, B, C}), 8'd0);
        step(TEMP);
        check("relatch_code", 8'({A, B, C}), 8'b101);

        // Randomized slow-changing sensors with glitches, acks and occasional resets.
        do_reset();
        cur = '0;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0) cur ^= 6'(1) << $urandom_range(0, 5);
            if ($urandom_range(0, 999) == 0) do_reset();
            step(cur);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
